// File: rtl/ha_array_pkg.sv
// Shared widths, row record and row-value helper for the approximate
// half-adder partial-product array and its downstream accumulator.
package ha_array_pkg;

  localparam int ROW_B_W   = 7;
  localparam int ROW_T_W   = 9;
  localparam int ROW_W     = 10;
  localparam int PAIR_W    = 13;
  localparam int PROD_W    = 16;
  localparam int N_ROWS    = 4;
  localparam int ROW_SHIFT = 2;

  typedef struct packed {
    logic [ROW_B_W-1:0] b;
    logic [ROW_T_W-1:0] t;
  } ha_row_t;

  // Carry bits sit two places above the sum bits within a row.
  function automatic logic [ROW_W-1:0] row_value(input ha_row_t row);
    row_value = ROW_W'(row.t) + (ROW_W'(row.b) << ROW_SHIFT);
  endfunction

endpackage

// File: rtl/ha_array_rows_accum_pipe_pipe_slot.sv
// One valid/ready pipeline slot: data register, full flag and the
// accept/drain logic that lets it refill in the same cycle it empties.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;
  logic         accept;

  assign in_ready  = !full_q | out_ready;
  assign accept    = in_valid & in_ready;
  assign out_valid = full_q;
  assign out_data  = data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (accept) begin
      full_d = 1'b1;
      data_d = in_data;
    end else if (out_ready) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/ha_array_rows_accum_pipe.sv
// Sums the four weighted half-adder rows into the 16-bit product over two
// valid/ready stages, carrying a sideband tag with each operand set.
module ha_array_rows_accum_pipe
  import ha_array_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [ROW_B_W-1:0] row0_b,
  input  logic [ROW_T_W-1:0] row0_t,
  input  logic [ROW_B_W-1:0] row1_b,
  input  logic [ROW_T_W-1:0] row1_t,
  input  logic [ROW_B_W-1:0] row2_b,
  input  logic [ROW_T_W-1:0] row2_t,
  input  logic [ROW_B_W-1:0] row3_b,
  input  logic [ROW_T_W-1:0] row3_t,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PROD_W-1:0]  out_prod,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_ovf
);

  localparam int S1_W  = TAG_W + 2 * PAIR_W;
  localparam int SUM_W = PROD_W + 1;
  localparam int S2_W  = TAG_W + SUM_W;

  logic [ROW_W-1:0]  r0_p0, r1_p0, r2_p0, r3_p0;
  logic [PAIR_W-1:0] p01_p0, p23_p0;
  logic [S1_W-1:0]   s1_in_p0, s1_data_p1;
  logic              vld_p1, s2_ready_p1;

  logic [PAIR_W-1:0] p01_p1, p23_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic [SUM_W-1:0]  sum_p1;
  logic [S2_W-1:0]   s2_in_p1, s2_data_p2;
  logic              vld_p2;

  // Stage 1: pair adjacent rows; odd row of each pair weighs 4x.
  assign r0_p0    = row_value('{b: row0_b, t: row0_t});
  assign r1_p0    = row_value('{b: row1_b, t: row1_t});
  assign r2_p0    = row_value('{b: row2_b, t: row2_t});
  assign r3_p0    = row_value('{b: row3_b, t: row3_t});
  assign p01_p0   = PAIR_W'(r0_p0) + (PAIR_W'(r1_p0) << ROW_SHIFT);
  assign p23_p0   = PAIR_W'(r2_p0) + (PAIR_W'(r3_p0) << ROW_SHIFT);
  assign s1_in_p0 = {in_tag, p01_p0, p23_p0};

  pipe_slot #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in_p0),
    .out_valid (vld_p1),
    .out_ready (s2_ready_p1),
    .out_data  (s1_data_p1)
  );

  // Stage 2: upper pair sits 16x above the lower pair; bit 16 flags wrap.
  assign {tag_p1, p01_p1, p23_p1} = s1_data_p1;
  assign sum_p1   = SUM_W'(p01_p1) + (SUM_W'(p23_p1) << (2 * ROW_SHIFT));
  assign s2_in_p1 = {tag_p1, sum_p1};

  pipe_slot #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (vld_p1),
    .in_ready  (s2_ready_p1),
    .in_data   (s2_in_p1),
    .out_valid (vld_p2),
    .out_ready (out_ready),
    .out_data  (s2_data_p2)
  );

  assign out_valid = vld_p2;
  assign {out_tag, out_ovf, out_prod} = s2_data_p2;

endmodule

// File: tb/tb_ha_array_rows_accum_pipe.sv
// Directed bench for the row accumulator pipe with a tag/product scoreboard.
module tb_ha_array_rows_accum_pipe;
  import ha_array_pkg::*;

  localparam int TAG_W = 4;
  localparam int ENT_W = TAG_W + 17;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [TAG_W-1:0]   in_tag = '0;
  ha_row_t [3:0]      rows_drv = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [PROD_W-1:0]  out_prod;
  logic [TAG_W-1:0]   out_tag;
  logic               out_ovf;

  int pass_cnt = 0;
  int total_cnt = 0;
  int pops = 0;
  int cyc = 0;
  logic [ENT_W-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ha_array_rows_accum_pipe #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tag    (in_tag),
    .row0_b    (rows_drv[0].b),
    .row0_t    (rows_drv[0].t),
    .row1_b    (rows_drv[1].b),
    .row1_t    (rows_drv[1].t),
    .row2_b    (rows_drv[2].b),
    .row2_t    (rows_drv[2].t),
    .row3_b    (rows_drv[3].b),
    .row3_t    (rows_drv[3].t),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_tag   (out_tag),
    .out_ovf   (out_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: the product is the plain weighted sum of the four rows.
  function automatic logic [ENT_W-1:0] model(input logic [TAG_W-1:0] tag, input ha_row_t [3:0] r);
    int s;
    logic [16:0] s17;
    s = 0;
    for (int i = 0; i < 4; i++)
      s += (int'(r[i].t) + 4 * int'(r[i].b)) * (1 << (2 * i));
    s17 = s[16:0];
    return {tag, s17[16], s17[15:0]};
  endfunction

  // Scoreboard: every completed output transfer must match the oldest entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'(out_tag), 32'hFFFF);
      end else begin
        logic [ENT_W-1:0] e;
        e = exp_q.pop_front();
        pops++;
        chk("out_tag", 32'(out_tag), 32'(e[ENT_W-1 -: TAG_W]));
        chk("out_ovf", 32'(out_ovf), 32'(e[16]));
        chk("out_prod", 32'(out_prod), 32'(e[15:0]));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [TAG_W-1:0] tag, input ha_row_t [3:0] r);
    bit done;
    done = 1'b0;
    in_tag   = tag;
    rows_drv = r;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(tag, r));
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 50 && (exp_q.size() != 0); k++) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic ha_row_t [3:0] uni_rows(input logic [6:0] b, input logic [8:0] t);
    ha_row_t [3:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i].b = b;
      r[i].t = t;
    end
    return r;
  endfunction

  initial begin
    ha_row_t [3:0] r;
    int c0, p0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_prod", 32'(out_prod), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // 1: zero rows, latency check
    send(4'h0, uni_rows(7'h00, 9'h000));
    @(negedge clk);
    chk("lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    wait_drain();

    // 2: single low bits in rows 0 and 2
    r = '0;
    r[0].t = 9'h001;
    r[2].b = 7'h01;
    chk("model_65", 32'(model(4'h0, r)), 32'd65);
    send(4'h9, r);
    wait_drain();

    // 3: all ones, wraps past 16 bits
    r = uni_rows(7'h7F, 9'h1FF);
    chk("model_max", 32'(model(4'h0, r)), 32'h1_5257);
    send(4'hA, r);
    wait_drain();

    // 4: backpressure with tags 1,2,3
    out_ready = 1'b0;
    send(4'h1, uni_rows(7'h11, 9'h022));
    send(4'h2, uni_rows(7'h33, 9'h144));
    in_tag   = 4'h3;
    rows_drv = 'x;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_tag", 32'(out_tag), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(4'h3, uni_rows(7'h55, 9'h066));
    wait_drain();

    // 5: 20 random sets at full rate
    c0 = cyc;
    p0 = pops;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 4; i++) begin
        r[i].b = 7'($urandom_range(0, 127));
        r[i].t = 9'($urandom_range(0, 511));
      end
      send(4'(n), r);
    end
    chk("stream_cycles", 32'(cyc - c0), 32'd20);
    wait_drain();
    chk("stream_results", 32'(pops - p0), 32'd20);

    // 6: async reset with both stages full
    out_ready = 1'b0;
    send(4'h5, uni_rows(7'h01, 9'h002));
    send(4'h6, uni_rows(7'h03, 9'h004));
    @(negedge clk);
    chk("full_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      chk("post_rst_ready", 32'(in_ready), 32'd1);
    end
    @(posedge clk); #1;
    send(4'hC, uni_rows(7'h40, 9'h100));
    wait_drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
